ex_issue_ctrl: RTL

EX_ISSUE_CTRL -- requirements
Module: ex_issue_ctrl

---
 rtl/ex_ctrl_pkg.sv | 25 ++
 rtl/ex_issue_ctrl_if.sv | 27 ++
 rtl/ex_scoreboard.sv | 57 +++++
 rtl/ex_issue_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/ex_ctrl_pkg.sv
// Shared opcode constants, issue FSM state type and scoreboard vector type
// for the execute-issue controller.
package ex_ctrl_pkg;

    localparam logic [7:0] OP_IMUL    = 8'hF7;
    localparam logic [7:0] OP_SYSCALL = 8'h05;
    localparam logic [7:0] OP_NOP     = 8'h90;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MULTI = 2'd1,
        DRAIN = 2'd2
    } ex_issue_state_t;

    // Element n of the vector tracks architectural register n.
    typedef logic [0:15] sb_vec_t;

    function automatic sb_vec_t reg_mask(input logic [3:0] idx);
        sb_vec_t m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/ex_issue_ctrl_if.sv
// Decoded-op offer channel into the issue controller (valid/ready handshake
// plus operand descriptors).
interface ex_issue_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_opcode;
  logic       in_twob;
  logic [3:0] in_src_a;
  logic [3:0] in_src_b;
  logic [3:0] in_dst;
  logic       in_src_a_en;
  logic       in_src_b_en;
  logic       in_dst_en;
  logic       in_dst2_en;

  modport master (
    output in_valid, in_opcode, in_twob, in_src_a, in_src_b, in_dst,
           in_src_a_en, in_src_b_en, in_dst_en, in_dst2_en,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_opcode, in_twob, in_src_a, in_src_b, in_dst,
           in_src_a_en, in_src_b_en, in_dst_en, in_dst2_en,
    output in_ready
  );
endinterface

// File: rtl/ex_scoreboard.sv
// Register-pending scoreboard: issue sets, writeback clears, set wins on a tie.
// EX_BYPASS_EN makes the hazard view include this cycle's writeback clear.
module ex_scoreboard
  import ex_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       issue,
  input  logic       dst_en,
  input  logic [3:0] dst,
  input  logic       dst2_en,
  input  logic       wb_valid,
  input  logic [3:0] wb_reg,
  input  logic       wb_reg2_en,
  output sb_vec_t    sb_reg,
  output sb_vec_t    sb_view
);

  sb_vec_t clr_mask;
  sb_vec_t set_mask;
  sb_vec_t sb_next;

  // Kept apart from the set path so the hazard view never depends on issue.
  always_comb begin
    clr_mask = '0;
    if (wb_valid) begin
      clr_mask = reg_mask(wb_reg);
      if (wb_reg2_en)
        clr_mask = clr_mask | reg_mask(4'd2);
    end
  end

  always_comb begin
    set_mask = '0;
    if (issue) begin
      if (dst_en)
        set_mask = set_mask | reg_mask(dst);
      if (dst2_en)
        set_mask = set_mask | reg_mask(4'd2);
    end
    sb_next = (sb_reg & ~clr_mask) | set_mask;
  end

`ifdef EX_BYPASS_EN
  assign sb_view = sb_reg & ~clr_mask;
`else
  assign sb_view = sb_reg;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      sb_reg <= '0;
    else
      sb_reg <= sb_next;
  end

endmodule

// File: rtl/ex_issue_ctrl.sv
// Execute-stage issue controller: hazard check, multi-cycle IMUL hold and
// syscall drain. Optional macro EX_BYPASS_EN (see ex_scoreboard).
module ex_issue_ctrl
  import ex_ctrl_pkg::*;
#(
  parameter int         MUL_LAT    = 3,
  parameter logic [7:0] SYSCALL_OP = OP_SYSCALL
) (
  input  logic                  clk,
  input  logic                  reset,
  ex_issue_ctrl_if.slave        issue,
  output logic                  ex_start,
  output logic [7:0]            ex_opcode,
  output logic                  ex_busy,
  input  logic                  wb_valid,
  input  logic [3:0]            wb_reg,
  input  logic                  wb_reg2_en,
  input  logic                  flush,
  output logic [15:0]           sb_bits
);

  localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 1);

  ex_issue_state_t state_reg, state_next;
  logic [3:0]      cnt_reg, cnt_next;
  sb_vec_t         sb_reg;
  sb_vec_t         sb_view;
  logic            hazard;
  logic            is_syscall;
  logic            is_imul;
  logic            sb_busy;
  logic            ready;
  logic            transfer;

  ex_scoreboard u_sb (
    .clk        (clk),
    .reset      (reset),
    .issue      (transfer),
    .dst_en     (issue.in_dst_en),
    .dst        (issue.in_dst),
    .dst2_en    (issue.in_dst2_en),
    .wb_valid   (wb_valid),
    .wb_reg     (wb_reg),
    .wb_reg2_en (wb_reg2_en),
    .sb_reg     (sb_reg),
    .sb_view    (sb_view)
  );

  // Scoreboard element n drives output bit n so sb_bits reads as a register mask.
  for (genvar gi = 0; gi < 16; gi++) begin : g_sb_out
    assign sb_bits[gi] = sb_reg[gi];
  end

  assign hazard = (issue.in_src_a_en & sb_view[issue.in_src_a])
                | (issue.in_src_b_en & sb_view[issue.in_src_b])
                | (issue.in_dst_en   & sb_view[issue.in_dst])
                | (issue.in_dst2_en  & sb_view[2]);

  assign is_syscall = (issue.in_opcode == SYSCALL_OP);
  assign is_imul    = (issue.in_opcode == OP_IMUL) & ~issue.in_twob;
  assign sb_busy    = (sb_reg != '0);

  assign ready = ~reset & (state_reg == IDLE) & ~hazard & ~flush
               & ~(is_syscall & sb_busy);
  assign issue.in_ready = ready;
  assign transfer = issue.in_valid & ready;
  assign ex_busy  = (state_reg == MULTI);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (transfer && is_imul) begin
          state_next = MULTI;
          cnt_next   = CNT_LOAD;
        end else if (issue.in_valid && is_syscall && sb_busy && !flush) begin
          state_next = DRAIN;
        end
      end
      MULTI: begin
        if (cnt_reg == 4'd0)
          state_next = IDLE;
        else
          cnt_next = cnt_reg - 4'd1;
      end
      DRAIN: begin
        if (flush || !sb_busy)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ex_start  <= 1'b0;
      ex_opcode <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ex_start  <= transfer;
      if (transfer)
        ex_opcode <= issue.in_opcode;
    end
  end

endmodule
